// File: rtl/al422_wr_ctrl.sv
// AL422 FIFO write-side controller.
// Waits for a start-of-frame byte, optionally syncs to the reader's frame
// start, pulses the AL422 write reset, then streams FRAME_BYTES bytes into
// the FIFO with one WE-low clock per accepted byte.
module al422_wr_ctrl #(
    parameter int FRAME_BYTES = 8192,
    parameter int WRST_CYCLES = 4,
    parameter bit SYNC_RD     = 1'b1
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_sof,
    output logic       s_ready,
    input  logic       rd_frame_start,
    output logic       al422_wrst_out,
    output logic       al422_we_out,
    output logic [7:0] al422_data_out,
    output logic       frame_done,
    output logic       sof_err,
    output logic       busy
);

    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam int WW = (WRST_CYCLES > 1) ? $clog2(WRST_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_BYTES - 1);
    localparam logic [WW-1:0] WRST_LAST = WW'(WRST_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_RD = 2'd1,
        WRST    = 2'd2,
        WRITE   = 2'd3
    } state_t;

    // A new frame either waits for the reader or goes straight to reset.
    localparam state_t RESTART = SYNC_RD ? WAIT_RD : WRST;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic          wrst_q, wrst_d;
    logic          we_q, we_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          busy_q, busy_d;
    logic          accept;
    logic          early_sof;

    // Next-state, handshake and registered-output next values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = '0;
        s_ready   = 1'b0;
        accept    = 1'b0;
        early_sof = 1'b0;

        case (state_q)
            IDLE: begin
                // Non-SOF bytes are swallowed; the SOF byte is left for WRITE.
                s_ready = !(s_valid && s_sof);
                if (s_valid && s_sof) begin
                    state_d = RESTART;
                end
            end
            WAIT_RD: begin
                if (rd_frame_start) begin
                    state_d = WRST;
                end
            end
            WRST: begin
                if (wcnt_q == WRST_LAST) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            WRITE: begin
                // A SOF after the first byte aborts; the byte is kept for the
                // restarted frame.
                early_sof = s_valid && s_sof && (cnt_q != '0);
                s_ready   = !early_sof;
                if (early_sof) begin
                    state_d = RESTART;
                end else if (s_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!in_nrst) begin
            s_ready = 1'b0;
        end

        wrst_d = (state_d != WRST);
        we_d   = !accept;
        data_d = accept ? s_data : data_q;
        done_d = accept && (cnt_q == LAST_IDX);
        err_d  = early_sof;
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge in_clk) begin
        if (!in_nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            wrst_q  <= 1'b1;
            we_q    <= 1'b1;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            wrst_q  <= wrst_d;
            we_q    <= we_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign al422_wrst_out = wrst_q;
    assign al422_we_out   = we_q;
    assign al422_data_out = data_q;
    assign frame_done     = done_q;
    assign sof_err        = err_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_al422_wr_ctrl.sv
// Testbench for al422_wr_ctrl: one instance with reader sync, one without,
// each driven from its own byte queue and checked every clock against a
// frame-level reference model.
module tb_al422_wr_ctrl;

    localparam int FB = 16;
    localparam int WC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic [7:0] sd [2];
    logic       sv [2];
    logic       ss [2];
    logic       rfs [2];
    logic       srdy [2];
    logic       wrst [2];
    logic       we [2];
    logic [7:0] wdat [2];
    logic       done [2];
    logic       err [2];
    logic       bsy [2];

    al422_wr_ctrl #(.FRAME_BYTES(FB), .WRST_CYCLES(WC), .SYNC_RD(1'b1)) u_dut_sync (
        .in_clk(clk), .in_nrst(nrst),
        .s_data(sd[0]), .s_valid(sv[0]), .s_sof(ss[0]), .s_ready(srdy[0]),
        .rd_frame_start(rfs[0]),
        .al422_wrst_out(wrst[0]), .al422_we_out(we[0]), .al422_data_out(wdat[0]),
        .frame_done(done[0]), .sof_err(err[0]), .busy(bsy[0])
    );

    al422_wr_ctrl #(.FRAME_BYTES(FB), .WRST_CYCLES(WC), .SYNC_RD(1'b0)) u_dut_async (
        .in_clk(clk), .in_nrst(nrst),
        .s_data(sd[1]), .s_valid(sv[1]), .s_sof(ss[1]), .s_ready(srdy[1]),
        .rd_frame_start(rfs[1]),
        .al422_wrst_out(wrst[1]), .al422_we_out(we[1]), .al422_data_out(wdat[1]),
        .frame_done(done[1]), .sof_err(err[1]), .busy(bsy[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: per instance, what the writer is doing in frame terms.
    bit         m_wait [2];
    int         m_wrst_left [2];
    bit         m_writing [2];
    int         m_count [2];
    int         wait_cnt [2];
    int         rd_delay [2];
    int         vprob [2];
    int         spur [2];
    int         frames [2];
    bit         e_we [2];
    bit         e_wrst [2];
    bit         e_done [2];
    bit         e_err [2];
    bit         e_busy [2];
    logic [7:0] e_data [2];

    logic [8:0] q0 [$];
    logic [8:0] q1 [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int src_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [8:0] src_front(input int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    task automatic src_pop(input int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic src_push(input int k, input logic [8:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic push_frame(input int k, input logic [7:0] first, input int n);
        src_push(k, {1'b1, first});
        for (int i = 1; i < n; i++) src_push(k, {1'b0, 8'($urandom)});
    endtask

    function automatic bit exp_ready(input int k);
        if (!nrst) return 1'b0;
        if (m_writing[k]) return !(sv[k] && ss[k] && m_count[k] != 0);
        if (m_wait[k] || m_wrst_left[k] > 0) return 1'b0;
        return !(sv[k] && ss[k]);
    endfunction

    task automatic start_frame(input int k);
        if (k == 0) begin
            m_wait[0]   = 1'b1;
            wait_cnt[0] = 0;
        end else begin
            m_wrst_left[1] = WC;
        end
    endtask

    task automatic model_step(input int k, input bit rdy);
        if (!nrst) begin
            m_wait[k] = 0; m_wrst_left[k] = 0; m_writing[k] = 0; m_count[k] = 0;
            e_we[k] = 1; e_wrst[k] = 1; e_data[k] = 8'h00;
            e_done[k] = 0; e_err[k] = 0; e_busy[k] = 0;
            return;
        end
        e_we[k] = 1; e_done[k] = 0; e_err[k] = 0;
        if (m_writing[k]) begin
            if (sv[k] && rdy) begin
                e_we[k] = 0;
                e_data[k] = sd[k];
                m_count[k]++;
                if (m_count[k] == FB) begin
                    m_writing[k] = 0;
                    e_done[k] = 1;
                    frames[k]++;
                end
            end else if (sv[k] && ss[k]) begin
                e_err[k] = 1;
                m_writing[k] = 0;
                start_frame(k);
            end
        end else if (m_wrst_left[k] > 0) begin
            m_wrst_left[k]--;
            if (m_wrst_left[k] == 0) begin
                m_writing[k] = 1;
                m_count[k] = 0;
            end
        end else if (m_wait[k]) begin
            if (rfs[k]) begin
                m_wait[k] = 0;
                m_wrst_left[k] = WC;
            end
        end else if (sv[k] && ss[k]) begin
            start_frame(k);
        end
        e_wrst[k] = (m_wrst_left[k] == 0);
        e_busy[k] = m_writing[k] || m_wait[k] || (m_wrst_left[k] > 0);
    endtask

    task automatic drive(input int k);
        if (src_size(k) > 0 && $urandom_range(99) < vprob[k]) begin
            sv[k] = 1'b1;
            {ss[k], sd[k]} = src_front(k);
        end else begin
            sv[k] = 1'b0;
            sd[k] = 8'($urandom);
            ss[k] = 1'($urandom);
        end
        if (m_wait[k]) begin
            wait_cnt[k]++;
            rfs[k] = (wait_cnt[k] == rd_delay[k]);
        end else begin
            rfs[k] = ($urandom_range(99) < spur[k]);
        end
    endtask

    task automatic cycle();
        bit r [2];
        for (int k = 0; k < 2; k++) drive(k);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            r[k] = exp_ready(k);
            chk($sformatf("s_ready%0d", k), 32'(srdy[k]), 32'(r[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (nrst && sv[k] && r[k]) src_pop(k);
            model_step(k, r[k]);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("we%0d", k),   32'(we[k]),   32'(e_we[k]));
            chk($sformatf("data%0d", k), 32'(wdat[k]), 32'(e_data[k]));
            chk($sformatf("wrst%0d", k), 32'(wrst[k]), 32'(e_wrst[k]));
            chk($sformatf("done%0d", k), 32'(done[k]), 32'(e_done[k]));
            chk($sformatf("err%0d", k),  32'(err[k]),  32'(e_err[k]));
            chk($sformatf("busy%0d", k), 32'(bsy[k]),  32'(e_busy[k]));
        end
    endtask

    function automatic bit pending();
        return src_size(0) > 0 || src_size(1) > 0 ||
               m_writing[0] || m_writing[1] || m_wait[0] || m_wait[1] ||
               m_wrst_left[0] > 0 || m_wrst_left[1] > 0;
    endfunction

    task automatic run(input string name, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_drained"}, 32'(pending()), 32'd0);
        repeat (2) cycle();
        $display("scenario %s: cycles=%0d frames=%0d/%0d", name, n, frames[0], frames[1]);
    endtask

    initial begin
        int n;
        nrst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_wrst_left[k] = 0; m_writing[k] = 0; m_count[k] = 0;
            wait_cnt[k] = 0; rd_delay[k] = 10; vprob[k] = 100; spur[k] = 0; frames[k] = 0;
            sd[k] = 8'h00; sv[k] = 1'b0; ss[k] = 1'b0; rfs[k] = 1'b0;
        end

        // Reset values, including s_ready held low during reset.
        src_push(0, {1'b1, 8'hA5});
        repeat (3) cycle();
        void'(q0.pop_front());
        nrst = 1'b1;
        $display("scenario reset: done");

        // Non-SOF bytes in idle are swallowed without a write.
        src_push(0, {1'b0, 8'h11});
        src_push(0, {1'b0, 8'h22});
        src_push(1, {1'b0, 8'h11});
        src_push(1, {1'b0, 8'h22});
        run("idle_junk", 20);

        // Full frames: reader pulse 10 clocks later on the synced instance.
        push_frame(0, 8'h2F, FB);
        push_frame(1, 8'h2F, FB);
        run("full_frame", 100);

        // Source stalls during the frame.
        vprob[0] = 50; vprob[1] = 50;
        push_frame(0, 8'($urandom), FB);
        push_frame(1, 8'($urandom), FB);
        run("stalled_frame", 300);
        vprob[0] = 100; vprob[1] = 100;

        // Early SOF at the 6th byte aborts and restarts with that byte.
        rd_delay[0] = 3;
        push_frame(0, 8'h5A, 5);
        push_frame(0, 8'hC3, FB);
        push_frame(1, 8'h5A, 5);
        push_frame(1, 8'hC3, FB);
        run("early_sof", 200);

        // Reset in the middle of a frame, then a clean frame.
        push_frame(0, 8'h77, FB);
        n = 0;
        while (!(m_writing[0] && m_count[0] == 8) && n < 200) begin
            cycle();
            n++;
        end
        chk("reach_byte8", 32'(m_count[0]), 32'd8);
        nrst = 1'b0;
        cycle();
        nrst = 1'b1;
        push_frame(0, 8'h88, FB);
        push_frame(1, 8'h88, FB);
        run("mid_reset", 200);

        // Random soak: junk, short frames, stalls, spurious reader pulses.
        for (int it = 0; it < 30; it++) begin
            for (int k = 0; k < 2; k++) begin
                vprob[k] = 30 + $urandom_range(70);
                rd_delay[k] = 1 + $urandom_range(11);
                spur[k] = 10;
                for (int j = 0; j < $urandom_range(2); j++) src_push(k, {1'b0, 8'($urandom)});
                if ($urandom_range(3) == 0) push_frame(k, 8'($urandom), 1 + $urandom_range(FB - 2));
                push_frame(k, 8'($urandom), FB);
            end
            run($sformatf("soak%0d", it), 600);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
